mult_div_unit: RTL



---
 rtl/mult_div_if.sv | 40 ++++
 rtl/mult_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_if.sv
// mult_div_if: bundle between the pipeline controller and the multiply/divide unit.
//
// Ports (signals):
//   md_start     controller -> unit  launch the operation selected by md_op
//   md_op        controller -> unit  00 mult, 01 multu, 10 div, 11 divu
//   md_srcA      controller -> unit  rs operand; also the mthi/mtlo write data
//   md_srcB      controller -> unit  rt operand
//   md_hi_write  controller -> unit  mthi
//   md_lo_write  controller -> unit  mtlo
//   md_busy      unit -> controller  operation in flight; the pipeline stalls while high
//   md_done      unit -> controller  one-cycle pulse once HI/LO hold a new result
//   md_hi/md_lo  unit -> controller  architectural HI/LO registers
//
// Handshake: md_start acts as "valid" and !md_busy as "ready". The unit
// samples md_start only while idle. Launch, write and stall semantics:
//   - A start sampled while busy is dropped, not queued.
//   - mthi/mtlo are honoured only while idle and only when md_start is low.
//   - md_done marks the single cycle in which the new HI/LO first appear.
interface mult_div_if #(parameter int WIDTH = 32);
  logic             md_start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] md_srcA;
  logic [WIDTH-1:0] md_srcB;
  logic             md_hi_write;
  logic             md_lo_write;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  modport master (
    output md_start, md_op, md_srcA, md_srcB, md_hi_write, md_lo_write,
    input  md_busy, md_done, md_hi, md_lo
  );

  modport slave (
    input  md_start, md_op, md_srcA, md_srcB, md_hi_write, md_lo_write,
    output md_busy, md_done, md_hi, md_lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle multiply/divide unit with architectural HI/LO.
//
// Ports:
//   clk          system clock, rising edge
//   rst_md       synchronous active-high reset; aborts any operation in flight
//   md_if        mult_div_if.slave bundle (start/op/operands/mthi/mtlo in,
//                busy/done/HI/LO out)
//   o_dbg_state  current FSM state (0 = IDLE, 1 = RUN)
//
// Multiply uses shift-add on magnitudes. The 64-bit accumulator holds
// {partial product, remaining multiplier bits} and shifts right once per cycle.
// Divide uses restoring division on magnitudes. The accumulator holds
// {partial remainder, dividend/quotient bits} and shifts left once per cycle.
// Signs are applied when the result is written at completion. HI/LO only
// change at that point, so they keep their old values during RUN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_md,
  mult_div_if.slave     md_if,
  output logic          o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [5:0]         r_cnt;
  logic               r_is_div;
  logic               r_neg_q;   // negate product (mult) or quotient (div)
  logic               r_neg_r;   // negate remainder (div only)
  logic               r_div0;    // divisor was zero at launch
  logic [WIDTH-1:0]   r_m;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  // Launch-time operand conditioning
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  // One iteration of each algorithm
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH:0]   w_div_sh;
  logic [WIDTH:0]     w_div_top;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;

  // Final signed results
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  always_comb begin
    w_signed = ~md_if.md_op[0];
    w_sa     = w_signed & md_if.md_srcA[WIDTH-1];
    w_sb     = w_signed & md_if.md_srcB[WIDTH-1];
    w_abs_a  = w_sa ? (~md_if.md_srcA + 1'b1) : md_if.md_srcA;
    w_abs_b  = w_sb ? (~md_if.md_srcB + 1'b1) : md_if.md_srcB;
  end

  always_comb begin
    // Shift-add: add the multiplicand if the current multiplier bit is set,
    // then shift the whole {sum, multiplier} right. The carry moves into the top bit.
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder can need WIDTH+1 bits, hence the
    // wide compare. When it fits, the difference is below 2^WIDTH.
    w_div_sh   = {r_acc, 1'b0};
    w_div_top  = w_div_sh[2*WIDTH:WIDTH];
    w_div_ge   = (w_div_top >= {1'b0, r_m});
    w_div_diff = w_div_top[WIDTH-1:0] - r_m;
    w_div_next = w_div_ge ? {w_div_diff, w_div_sh[WIDTH-1:1], 1'b1}
                          : {w_div_top[WIDTH-1:0], w_div_sh[WIDTH-1:0]};

    w_acc_next = r_is_div ? w_div_next : w_mul_next;
  end

  always_comb begin
    w_prod   = r_neg_q ? (~w_acc_next + 1'b1) : w_acc_next;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      // Divide by zero gives remainder = |A| from the algorithm itself. Applying
      // the dividend sign recovers the captured srcA. Only the quotient is forced.
      w_res_hi = r_neg_r ? (~w_acc_next[2*WIDTH-1:WIDTH] + 1'b1)
                         : w_acc_next[2*WIDTH-1:WIDTH];
      if (r_div0)
        w_res_lo = '1;
      else
        w_res_lo = r_neg_q ? (~w_acc_next[WIDTH-1:0] + 1'b1)
                           : w_acc_next[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_md) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_m      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (md_if.md_start) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= md_if.md_op[1];
            r_neg_q  <= w_sa ^ w_sb;
            r_neg_r  <= w_sa & md_if.md_op[1];
            r_div0   <= (md_if.md_srcB == '0);
            if (md_if.md_op[1]) begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_a};
              r_m   <= w_abs_b;
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_abs_b};
              r_m   <= w_abs_a;
            end
          end else begin
            if (md_if.md_hi_write) r_hi <= md_if.md_srcA;
            if (md_if.md_lo_write) r_lo <= md_if.md_srcA;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign md_if.md_busy = r_busy;
  assign md_if.md_done = r_done;
  assign md_if.md_hi   = r_hi;
  assign md_if.md_lo   = r_lo;
  assign o_dbg_state   = r_state;

endmodule
